// File: rtl/dshot_pkg.sv
// Shared constants, FSM state encodings and the CRC helper for the DShot frame decoder.
package dshot_pkg;

    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE  = 2'd0;
    localparam state_t ST_HIGH  = 2'd1;
    localparam state_t ST_LOW   = 2'd2;
    localparam state_t ST_CHECK = 2'd3;

    localparam int DSHOT_CMD_MAX = 47;
    localparam int THROTTLE_MIN  = 48;
    localparam int SCALE_MUL     = 131;
    localparam int SCALE_SHIFT   = 10;

    // XOR of the three nibbles of the 12-bit value+telemetry field.
    function automatic logic [3:0] dshot_crc(input logic [11:0] v);
        return v[3:0] ^ v[7:4] ^ v[11:8];
    endfunction

endpackage

// File: rtl/dshot_pulse_timer.sv
// Synchronises the DShot line, detects edges and times high/low phases for bit classification.
// With DSHOT_BIDIR_EN defined the line is idle-high and pulses are low-going.
module dshot_pulse_timer #(
    parameter int BIT_CLKS    = 83,
    parameter int ONE_THR     = 41,
    parameter int GLITCH_CLKS = 10,
    parameter int GAP_CLKS    = 166
) (
    input  logic clk,
    input  logic rst,
    input  logic dshot_in,
    output logic rise,
    output logic fall,
    output logic bit_val,
    output logic glitch,
    output logic hi_timeout,
    output logic gap_timeout
);

    localparam int CNT_W = $clog2(GAP_CLKS + 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] ONE_C    = CNT_W'(ONE_THR);
    localparam logic [CNT_W-1:0] GLITCH_C = CNT_W'(GLITCH_CLKS);
    localparam logic [CNT_W-1:0] BIT_C    = CNT_W'(BIT_CLKS);
    localparam logic [CNT_W-1:0] GAP_C    = CNT_W'(GAP_CLKS);

`ifdef DSHOT_BIDIR_EN
    localparam logic IDLE_LVL = 1'b1;
`else
    localparam logic IDLE_LVL = 1'b0;
`endif

    logic sync_p0;
    logic sync_p1;
    logic line;
    logic line_d;
    logic [CNT_W-1:0] hi_cnt;
    logic [CNT_W-1:0] lo_cnt;

    // Stage p0/p1: two-flop synchroniser, reset to the idle level so no false edge follows reset
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_p0 <= IDLE_LVL;
            sync_p1 <= IDLE_LVL;
        end else begin
            sync_p0 <= dshot_in;
            sync_p1 <= sync_p0;
        end
    end

    // Active-pulse view of the line: 1 while a pulse is in progress, either polarity
    assign line = sync_p1 ^ IDLE_LVL;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            line_d <= 1'b0;
        end else begin
            line_d <= line;
        end
    end

    assign rise = line & ~line_d;
    assign fall = ~line & line_d;

    // Counters hold the number of cycles spent in the current phase, saturating
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hi_cnt <= '0;
            lo_cnt <= '0;
        end else begin
            if (rise) begin
                hi_cnt <= CNT_ONE;
            end else if (line && hi_cnt != CNT_MAX) begin
                hi_cnt <= hi_cnt + CNT_ONE;
            end

            if (fall) begin
                lo_cnt <= CNT_ONE;
            end else if (!line && lo_cnt != CNT_MAX) begin
                lo_cnt <= lo_cnt + CNT_ONE;
            end
        end
    end

    assign bit_val     = (hi_cnt >= ONE_C);
    assign glitch      = (hi_cnt < GLITCH_C);
    assign hi_timeout  = line & (hi_cnt >= BIT_C);
    assign gap_timeout = ~line & (lo_cnt >= GAP_C);

endmodule

// File: rtl/dshot_frame_decoder.sv
// DShot frame decoder: recovers 16-bit frames, checks CRC, splits commands from throttle.
// Optional macro DSHOT_BIDIR_EN selects inverted line polarity and inverted CRC.
module dshot_frame_decoder
    import dshot_pkg::*;
#(
    parameter int CLK_HZ     = 50_000_000,
    parameter int DSHOT_KBPS = 600
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        dshot_in,
    output logic [7:0]  throttle_out,
    output logic [10:0] throttle_raw,
    output logic        telem_req,
    output logic [5:0]  cmd_out,
    output logic        cmd_valid,
    output logic        frame_valid,
    output logic        frame_err
);

    localparam int BIT_CLKS    = CLK_HZ / (DSHOT_KBPS * 1000);
    localparam int ONE_THR     = BIT_CLKS / 2;
    localparam int GLITCH_CLKS = BIT_CLKS / 8;
    localparam int GAP_CLKS    = 2 * BIT_CLKS;

    localparam logic [4:0]  FRAME_BITS = 5'd16;
    localparam logic [10:0] CMD_MAX_V  = 11'(DSHOT_CMD_MAX);
    localparam logic [10:0] THR_MIN_V  = 11'(THROTTLE_MIN);

    logic        rise;
    logic        fall;
    logic        bit_val;
    logic        glitch;
    logic        hi_timeout;
    logic        gap_timeout;

    state_t      state;
    state_t      state_nxt;
    logic        err_evt;
    logic        shift_en;
    logic        start;
    logic [4:0]  bit_cnt;
    logic [15:0] shreg;
    logic [3:0]  crc_exp;
    logic        crc_ok;
    logic [10:0] value;

    dshot_pulse_timer #(
        .BIT_CLKS    (BIT_CLKS),
        .ONE_THR     (ONE_THR),
        .GLITCH_CLKS (GLITCH_CLKS),
        .GAP_CLKS    (GAP_CLKS)
    ) u_timer (
        .clk         (clk),
        .rst         (rst),
        .dshot_in    (dshot_in),
        .rise        (rise),
        .fall        (fall),
        .bit_val     (bit_val),
        .glitch      (glitch),
        .hi_timeout  (hi_timeout),
        .gap_timeout (gap_timeout)
    );

    // 18-bit product keeps (2047-48)*131 exact; the top byte after the shift is 0..255.
    function automatic logic [7:0] scale_throttle(input logic [10:0] v);
        logic [17:0] prod;
        prod = 18'(v - THR_MIN_V) * 18'(SCALE_MUL);
        return 8'(prod >> SCALE_SHIFT);
    endfunction

    always_comb begin
        state_nxt = state;
        err_evt   = 1'b0;
        shift_en  = 1'b0;
        start     = 1'b0;
        case (state)
            ST_IDLE: begin
                if (rise) begin
                    state_nxt = ST_HIGH;
                    start     = 1'b1;
                end
            end
            ST_HIGH: begin
                if (fall) begin
                    if (glitch) begin
                        err_evt   = 1'b1;
                        state_nxt = ST_IDLE;
                    end else begin
                        shift_en  = 1'b1;
                        state_nxt = ST_LOW;
                    end
                end else if (hi_timeout) begin
                    err_evt   = 1'b1;
                    state_nxt = ST_IDLE;
                end
            end
            ST_LOW: begin
                // A pulse after the 16th bit means an over-long frame
                if (rise) begin
                    if (bit_cnt == FRAME_BITS) begin
                        err_evt   = 1'b1;
                        state_nxt = ST_IDLE;
                    end else begin
                        state_nxt = ST_HIGH;
                    end
                end else if (gap_timeout) begin
                    if (bit_cnt == FRAME_BITS) begin
                        state_nxt = ST_CHECK;
                    end else begin
                        err_evt   = 1'b1;
                        state_nxt = ST_IDLE;
                    end
                end
            end
            ST_CHECK: begin
                state_nxt = ST_IDLE;
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bit_cnt <= '0;
            shreg   <= '0;
        end else if (start) begin
            bit_cnt <= '0;
            shreg   <= '0;
        end else if (shift_en) begin
            bit_cnt <= bit_cnt + 5'd1;
            shreg   <= {shreg[14:0], bit_val};
        end
    end

    always_comb begin
`ifdef DSHOT_BIDIR_EN
        crc_exp = ~dshot_crc(shreg[15:4]);
`else
        crc_exp = dshot_crc(shreg[15:4]);
`endif
        crc_ok = (crc_exp == shreg[3:0]);
        value  = shreg[15:5];
    end

    // Output stage: pulses default low, held outputs change only on a CRC-good frame
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            throttle_out <= '0;
            throttle_raw <= '0;
            telem_req    <= 1'b0;
            cmd_out      <= '0;
            cmd_valid    <= 1'b0;
            frame_valid  <= 1'b0;
            frame_err    <= 1'b0;
        end else begin
            cmd_valid   <= 1'b0;
            frame_valid <= 1'b0;
            frame_err   <= err_evt;
            if (state == ST_CHECK) begin
                if (crc_ok) begin
                    frame_valid  <= 1'b1;
                    throttle_raw <= value;
                    telem_req    <= shreg[4];
                    if (value == 11'd0) begin
                        throttle_out <= '0;
                    end else if (value <= CMD_MAX_V) begin
                        cmd_out      <= value[5:0];
                        cmd_valid    <= 1'b1;
                        throttle_out <= '0;
                    end else begin
                        throttle_out <= scale_throttle(value);
                    end
                end else begin
                    frame_err <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_dshot_frame_decoder.sv
// Directed plus randomized DShot frames checked against a behavioural frame model.
module tb_dshot_frame_decoder;

    localparam int BIT_CLKS = 83;
    localparam int GAP_CLKS = 2 * BIT_CLKS;
    localparam int SETTLE   = 250;

`ifdef DSHOT_BIDIR_EN
    localparam logic        TB_IDLE  = 1'b1;
    localparam logic [15:0] TP_FRAME = 16'h82C9;
`else
    localparam logic        TB_IDLE  = 1'b0;
    localparam logic [15:0] TP_FRAME = 16'h82C6;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        dshot_in;
    logic [7:0]  throttle_out;
    logic [10:0] throttle_raw;
    logic        telem_req;
    logic [5:0]  cmd_out;
    logic        cmd_valid;
    logic        frame_valid;
    logic        frame_err;

    int vectors = 0;
    int miscompares = 0;

    int cyc = 0;
    int n_valid = 0, n_err = 0, n_cmd = 0, n_both = 0;
    int last_valid_cyc = 0;
    int last_fall_cyc = 0;
    int s_v, s_e, s_c;

    int m_thr = 0, m_raw = 0, m_telem = 0, m_cmd = 0;

    dshot_frame_decoder dut (
        .clk          (clk),
        .rst          (rst),
        .dshot_in     (dshot_in),
        .throttle_out (throttle_out),
        .throttle_raw (throttle_raw),
        .telem_req    (telem_req),
        .cmd_out      (cmd_out),
        .cmd_valid    (cmd_valid),
        .frame_valid  (frame_valid),
        .frame_err    (frame_err)
    );

    always #10 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (frame_valid) begin
            n_valid <= n_valid + 1;
            last_valid_cyc <= cyc;
        end
        if (frame_err) n_err <= n_err + 1;
        if (cmd_valid) n_cmd <= n_cmd + 1;
        if (frame_valid && frame_err) n_both <= n_both + 1;
    end

    task automatic check(input string tag, input int obs, input int exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic lvl);
        dshot_in = lvl ^ TB_IDLE;
    endtask

    task automatic send_bits(input logic [15:0] w, input int nbits);
        logic b;
        int h;
        for (int i = 0; i < nbits; i++) begin
            b = w[15-i];
            h = b ? 61 + int'($urandom_range(0, 2)) : 30 + int'($urandom_range(0, 2));
            @(negedge clk);
            drive(1'b1);
            repeat (h) @(negedge clk);
            drive(1'b0);
            last_fall_cyc = cyc;
            repeat (BIT_CLKS - h - 1) @(negedge clk);
        end
    endtask

    task automatic snapshot();
        s_v = n_valid;
        s_e = n_err;
        s_c = n_cmd;
    endtask

    task automatic check_all(input string tag, input int ev, input int ee, input int ec);
        check({tag, ".valid"}, n_valid - s_v, ev);
        check({tag, ".err"},   n_err - s_e,   ee);
        check({tag, ".cmdv"},  n_cmd - s_c,   ec);
        check({tag, ".thr"},   int'(throttle_out), m_thr);
        check({tag, ".raw"},   int'(throttle_raw), m_raw);
        check({tag, ".telem"}, int'(telem_req),    m_telem);
        check({tag, ".cmd"},   int'(cmd_out),      m_cmd);
    endtask

    // Reference: frame -> expected pulses and held outputs, straight from the frame rules
    task automatic run_frame(input logic [15:0] w, input int nbits, input string tag);
        int word, v12, crc, value, ev, ee, ec;
        snapshot();
        send_bits(w, nbits);
        repeat (SETTLE) @(negedge clk);
        ev = 0; ee = 0; ec = 0;
        word  = int'(w);
        v12   = word / 16;
        value = word / 32;
        crc   = (v12 ^ (v12 / 16) ^ (v12 / 256)) % 16;
`ifdef DSHOT_BIDIR_EN
        crc   = 15 - crc;
`endif
        if (nbits != 16) begin
            ee = 1;
        end else if (crc != word % 16) begin
            ee = 1;
        end else begin
            ev = 1;
            m_raw = value;
            m_telem = v12 % 2;
            if (value == 0) begin
                m_thr = 0;
            end else if (value < 48) begin
                m_cmd = value;
                m_thr = 0;
                ec = 1;
            end else begin
                m_thr = ((value - 48) * 131) / 1024;
            end
        end
        check_all(tag, ev, ee, ec);
    endtask

    function automatic logic [15:0] make_frame(input int value, input int telem, input bit bad);
        int v12, crc;
        v12 = value * 2 + telem;
        crc = (v12 ^ (v12 >> 4) ^ (v12 >> 8)) & 15;
`ifdef DSHOT_BIDIR_EN
        crc = crc ^ 15;
`endif
        if (bad) crc = crc ^ int'($urandom_range(1, 15));
        return 16'(v12 * 16 + crc);
    endfunction

    initial begin
        int value;
        rst = 1'b1;
        drive(1'b0);
        repeat (5) @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        snapshot();
        check_all("reset", 0, 0, 0);

        run_frame(TP_FRAME, 16, "tp_frame");
        check("tp_thr127", int'(throttle_out), 127);
        check("tp_raw1046", int'(throttle_raw), 1046);
        check("latency", last_valid_cyc - last_fall_cyc, GAP_CLKS + 4);

        run_frame(16'hFFFF, 16, "full");
        run_frame(16'h0606, 16, "min48");

        run_frame(TP_FRAME, 16, "tp_again");
        run_frame(TP_FRAME ^ 16'h0001, 16, "bad_crc");
        check("badcrc_hold", int'(throttle_out), 127);

        run_frame(make_frame(5, 0, 1'b0), 16, "cmd5");
        check("cmd5_val", int'(cmd_out), 5);

        // 40 ns pulse on the line
        snapshot();
        @(negedge clk);
        drive(1'b1);
        repeat (2) @(negedge clk);
        drive(1'b0);
        repeat (SETTLE) @(negedge clk);
        check_all("glitch", 0, 1, 0);

        run_frame(TP_FRAME, 15, "trunc15");
        run_frame(16'h0000, 16, "disarm");
        run_frame(make_frame(300, 1, 1'b0), 16, "thr300");

        // Reset in the middle of a frame
        snapshot();
        send_bits(TP_FRAME, 8);
        rst = 1'b1;
        m_thr = 0; m_raw = 0; m_telem = 0; m_cmd = 0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (SETTLE) @(negedge clk);
        check_all("midreset", 0, 0, 0);
        run_frame(TP_FRAME, 16, "post_reset");

        for (int i = 0; i < 14; i++) begin
            if ($urandom_range(0, 3) == 0) value = int'($urandom_range(1, 47));
            else value = int'($urandom_range(0, 2047));
            run_frame(make_frame(value, int'($urandom_range(0, 1)), $urandom_range(0, 4) == 0),
                      16, $sformatf("rand%0d", i));
        end

        check("no_overlap", n_both, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/dshot_frame_decoder.md
Name: dshot_frame_decoder

Overview:
- Upstream stage of throttle_curve.
- Oversamples a raw DShot line and measures each pulse's high time to recover 16-bit frames: 11-bit value, telemetry bit, 4-bit CRC.
- Checks the CRC, splits motor commands from throttle, and rescales throttle to the 8-bit throttle_in domain that throttle_curve consumes.
- Held outputs update only on valid frames; bad frames are flagged and dropped.

Parameters:
- CLK_HZ, 50_000_000, system clock frequency.
- DSHOT_KBPS, 600, DShot bit rate in kbit/s (150/300/600/1200).
- Derived localparams:
  - BIT_CLKS = CLK_HZ/(DSHOT_KBPS*1000); 83 at defaults.
  - ONE_THR = BIT_CLKS/2.
  - GLITCH_CLKS = BIT_CLKS/8.
  - GAP_CLKS = 2*BIT_CLKS.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-high reset.
- dshot_in  in  1  raw asynchronous DShot line.
- throttle_out  out  8  scaled throttle to throttle_curve.throttle_in; held.
- throttle_raw  out  11  last valid 11-bit value; held.
- telem_req  out  1  telemetry bit of last valid frame; held.
- cmd_out  out  6  command number when value is 1..47; held.
- cmd_valid  out  1  1-cycle pulse: valid frame carried a command (1..47).
- frame_valid  out  1  1-cycle pulse: any CRC-good frame accepted.
- frame_err  out  1  1-cycle pulse: CRC, glitch, timing or length error.

Behaviour:
- Reset values:
  - All outputs 0.
  - FSM in IDLE; bit counter, shift register and timers cleared.
  - Reset mid-frame discards partial bits; no pulse is issued.
- Input handling: dshot_in goes through a 2-flop synchroniser giving dshot_s. All timing below is relative to dshot_s.
- FSM states: IDLE, HIGH, LOW, CHECK.
  - IDLE: on dshot_s rising edge -> HIGH, clear hi_cnt.
  - HIGH: hi_cnt counts.
    - Falling edge with hi_cnt < GLITCH_CLKS: frame_err -> IDLE.
    - Otherwise shift in bit = (hi_cnt >= ONE_THR), MSB first, bit_cnt++, -> LOW.
    - hi_cnt reaching BIT_CLKS (stuck high): frame_err -> IDLE.
  - LOW: lo_cnt counts.
    - Rising edge with bit_cnt < 16: -> HIGH.
    - Rising edge with bit_cnt == 16 (17th pulse): frame_err -> IDLE.
    - lo_cnt reaching GAP_CLKS with bit_cnt == 16: -> CHECK.
    - lo_cnt reaching GAP_CLKS with bit_cnt < 16: frame_err -> IDLE.
  - CHECK: single cycle, then -> IDLE.
- CRC: v = frame[15:4]; crc = (v ^ v>>4 ^ v>>8) & 0xF; compare against frame[3:0].
- Outputs are registered. frame_valid/frame_err assert on the cycle after CHECK. Total latency is GAP_CLKS+2 clocks after the 16th falling edge of dshot_s.
- On CRC pass:
  - throttle_raw = frame[15:5]; telem_req = frame[4]; frame_valid = 1.
  - value 0 (disarm): throttle_out = 0, cmd_valid = 0.
  - value 1..47: cmd_out = value, cmd_valid = 1, throttle_out forced to 0.
  - value 48..2047: throttle_out = ((value-48)*131) >> 10, range 0..255. Use an 18-bit intermediate, no saturation needed.
- On CRC fail: frame_err = 1; all held outputs keep their previous values.
- A rising edge while in CHECK is ignored. Frames must be separated by at least GAP_CLKS.
- frame_valid and frame_err are never asserted together.

Optional Feature:
- Macro: DSHOT_BIDIR_EN.
- Defined (bidirectional DShot):
  - Decoder operates on ~dshot_s (idle-high line, low-going pulses).
  - CRC is inverted: expected frame[3:0] = ~crc & 0xF.
- Undefined: normal polarity and plain CRC.

Decomposition:
- Package dshot_pkg:
  - state enum {IDLE, HIGH, LOW, CHECK}.
  - DSHOT_CMD_MAX = 47, THROTTLE_MIN = 48, SCALE_MUL = 131, SCALE_SHIFT = 10.
  - dshot_crc function.
- One natural sub-module: dshot_pulse_timer (synchroniser, edge detect, hi/lo counters, bit/glitch/timeout classification). The top holds the FSM, CRC and output registers.

Test Plan:
- Frame 0x82C6 (value 1046, telem 0, crc 6) at 600 kbit/s -> frame_valid 1 cycle; throttle_raw = 1046, throttle_out = 127, telem_req = 0, cmd_valid = 0.
- Frame 0xFFFF (value 2047, telem 1, crc F), then 0x0606 (value 48) -> throttle_out 255 then 0; telem_req 1 then 0.
- Frame 0x82C7 (bad CRC) after 0x82C6 -> frame_err 1 cycle, no frame_valid; throttle_out stays 127.
- Frame with 0x0000 CRC-correct command value 5, then 40-ns glitch pulse, then 15-bit truncated frame -> cmd_valid with cmd_out = 5, throttle_out 0; then two frame_err pulses, outputs unchanged.
- rst asserted after bit 8 of a frame, released, then 0x82C6 sent -> no pulse for the partial frame; clean decode of the next frame.
- With DSHOT_BIDIR_EN and inverted line: frame 0x82C9 -> frame_valid, throttle_out 127; 0x82C6 -> frame_err.
